// File: rtl/streaming_fifo_pkg.sv
// Shared sizing helpers and parameter legality rules for the streaming FIFO monitor.
package streaming_fifo_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // Occupancy must be able to represent DEPTH itself, hence one extra bit.
  function automatic int unsigned count_width(input int unsigned depth);
    return clog2(depth) + 1;
  endfunction

  function automatic bit params_legal(input int unsigned width, input int unsigned depth,
                                      input int unsigned af, input int unsigned ae);
    bit ok;
    ok = 1'b1;
    if (width < 1 || width > 1024) ok = 1'b0;
    if (depth < 2 || depth > 65536) ok = 1'b0;
    if ((depth & (depth - 1)) != 0) ok = 1'b0;
    if (af > depth || ae >= depth) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/streaming_fifo_mem.sv
// Simple dual-port storage: one write port, one read port with a registered output.
module streaming_fifo_mem #(
  parameter int unsigned Width   = 8,
  parameter int unsigned Entries = 15,
  parameter int unsigned Aw      = 4
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [Aw-1:0]    waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [Aw-1:0]    raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Entries];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/streaming_fifo_mon.sv
// AXI-Stream FIFO with occupancy monitor: output register plus DEPTH-1 words of storage,
// registered threshold flags and a clearable high-water mark.
module streaming_fifo_mon
  import streaming_fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16384,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic [WIDTH-1:0]       in0_V_V_TDATA,
  input  logic                   in0_V_V_TVALID,
  output logic                   in0_V_V_TREADY,
  output logic [WIDTH-1:0]       out_V_V_TDATA,
  output logic                   out_V_V_TVALID,
  input  logic                   out_V_V_TREADY,
  output logic [clog2(DEPTH):0]  count,
  output logic [clog2(DEPTH):0]  maxcount,
  input  logic                   maxcount_clr,
  output logic                   almost_full,
  output logic                   almost_empty
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if (!params_legal(WIDTH, DEPTH, AF_THRESH, AE_THRESH)) begin : gen_param_err
    $error("streaming_fifo_mon: illegal WIDTH/DEPTH/threshold parameters");
  end

  // Storage pointers walk the DEPTH-1 storage entries without a gap.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 2)) ? '0 : p + 1'b1;
  endfunction

  logic [CW-1:0]    count_q, count_d, maxcount_q, maxcount_d, mem_cnt;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic             out_valid_q, out_valid_d;
  logic             sel_byp_q, sel_byp_d;
  logic [WIDTH-1:0] byp_q, byp_d;
  logic             af_q, af_d, ae_q, ae_d;
  logic             push, pop, load_out, mem_has, mem_re, mem_we, byp_load;
  logic [WIDTH-1:0] mem_rdata;

  assign in0_V_V_TREADY = (count_q < CW'(DEPTH));
  assign push    = in0_V_V_TVALID & in0_V_V_TREADY;
  assign pop     = out_valid_q & out_V_V_TREADY;
  assign mem_cnt = count_q - CW'(out_valid_q);

  always_comb begin
    load_out    = ~out_valid_q | pop;
    mem_has     = (mem_cnt != '0);
    mem_re      = load_out & mem_has;
    // An empty storage stage lets a push go straight to the output register.
    byp_load    = load_out & ~mem_has & push;
    mem_we      = push & ~byp_load;
    out_valid_d = load_out ? (mem_has | push) : out_valid_q;
    sel_byp_d   = sel_byp_q;
    if (mem_re) sel_byp_d = 1'b0;
    else if (byp_load) sel_byp_d = 1'b1;
    byp_d    = byp_load ? in0_V_V_TDATA : byp_q;
    rd_ptr_d = mem_re ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = mem_we ? ptr_inc(wr_ptr_q) : wr_ptr_q;

    count_d = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;

    maxcount_d = maxcount_q;
    if (maxcount_clr) maxcount_d = count_d;
    else if (count_d > maxcount_q) maxcount_d = count_d;

    af_d = (count_d >= CW'(AF_THRESH));
    ae_d = (count_d <= CW'(AE_THRESH));
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      count_q     <= '0;
      maxcount_q  <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      sel_byp_q   <= 1'b0;
      af_q        <= 1'b0;
      ae_q        <= 1'b1;
    end else begin
      count_q     <= count_d;
      maxcount_q  <= maxcount_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      out_valid_q <= out_valid_d;
      sel_byp_q   <= sel_byp_d;
      af_q        <= af_d;
      ae_q        <= ae_d;
    end
  end

  // Data-only register; contents are don't-care while the output is invalid.
  always_ff @(posedge ap_clk) begin
    byp_q <= byp_d;
  end

  streaming_fifo_mem #(
    .Width   (WIDTH),
    .Entries (DEPTH - 1),
    .Aw      (AW)
  ) u_mem (
    .clk_i   (ap_clk),
    .we_i    (mem_we & ~ap_rst),
    .waddr_i (wr_ptr_q),
    .wdata_i (in0_V_V_TDATA),
    .re_i    (mem_re & ~ap_rst),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  assign out_V_V_TDATA  = sel_byp_q ? byp_q : mem_rdata;
  assign out_V_V_TVALID = out_valid_q;
  assign count          = count_q;
  assign maxcount       = maxcount_q;
  assign almost_full    = af_q;
  assign almost_empty   = ae_q;

endmodule

// File: tb/tb_streaming_fifo_mon.sv
// Directed bench for streaming_fifo_mon (WIDTH=8, DEPTH=16) with a queue reference model.
module tb_streaming_fifo_mon;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid, in_ready;
  logic [7:0] out_data;
  logic       out_valid, out_ready;
  logic [4:0] count, maxcount;
  logic       max_clr, af, ae;

  int checks   = 0;
  int failures = 0;

  logic [7:0] model_q[$];
  int         model_max = 0;

  always #5 clk = ~clk;

  streaming_fifo_mon #(
    .WIDTH (8),
    .DEPTH (16)
  ) dut (
    .ap_clk         (clk),
    .ap_rst         (rst),
    .in0_V_V_TDATA  (in_data),
    .in0_V_V_TVALID (in_valid),
    .in0_V_V_TREADY (in_ready),
    .out_V_V_TDATA  (out_data),
    .out_V_V_TVALID (out_valid),
    .out_V_V_TREADY (out_ready),
    .count          (count),
    .maxcount       (maxcount),
    .maxcount_clr   (max_clr),
    .almost_full    (af),
    .almost_empty   (ae)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; the model predicts handshakes, order and monitor outputs.
  task automatic drive(input logic iv, input logic [7:0] d, input logic ordy,
                       input logic clr, input logic r);
    bit m_push, m_pop;
    int n;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    max_clr   = clr;
    rst       = r;
    #1;
    check_eq("tready", 32'(in_ready), 32'(model_q.size() < 16));
    check_eq("tvalid", 32'(out_valid), 32'(model_q.size() > 0));
    m_push = !r && iv && (model_q.size() < 16);
    m_pop  = !r && ordy && (model_q.size() > 0);
    if (m_pop) check_eq("order", 32'(out_data), 32'(model_q[0]));
    @(posedge clk);
    #1;
    if (r) begin
      model_q.delete();
      model_max = 0;
    end else begin
      if (m_pop) void'(model_q.pop_front());
      if (m_push) model_q.push_back(d);
      n = model_q.size();
      if (clr) model_max = n;
      else if (n > model_max) model_max = n;
    end
    check_eq("count", 32'(count), 32'(model_q.size()));
    check_eq("maxcount", 32'(maxcount), 32'(model_max));
    check_eq("almost_full", 32'(af), 32'(model_q.size() >= 14));
    check_eq("almost_empty", 32'(ae), 32'(model_q.size() <= 2));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; max_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_count", 32'(count), 0);
    check_eq("rst_maxcount", 32'(maxcount), 0);
    check_eq("rst_tvalid", 32'(out_valid), 0);
    check_eq("rst_tready", 32'(in_ready), 1);
    check_eq("rst_ae", 32'(ae), 1);
    check_eq("rst_af", 32'(af), 0);

    // Single push shows up on the next cycle.
    drive(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    check_eq("lat_tvalid", 32'(out_valid), 1);
    check_eq("lat_tdata", 32'(out_data), 32'h0000_00A5);
    check_eq("lat_count", 32'(count), 1);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Fill to capacity with the consumer stalled; a 17th word bounces.
    for (int i = 0; i < 16; i++) drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    check_eq("full_tready", 32'(in_ready), 0);
    check_eq("full_count", 32'(count), 16);
    check_eq("full_af", 32'(af), 1);
    check_eq("full_max", 32'(maxcount), 16);
    drive(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    check_eq("full_reject", 32'(count), 16);
    check_eq("full_head", 32'(out_data), 0);

    // Full FIFO with push and pop held high.
    for (int i = 0; i < 40; i++) drive(1'b1, 8'(100 + i), 1'b1, 1'b0, 1'b0);
    check_eq("stream_no_ovf", 32'(count <= 5'd16), 1);
    repeat (20) drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check_eq("drained", 32'(count), 0);

    // Half full, continuous streaming across pointer wrap.
    for (int i = 0; i < 8; i++) drive(1'b1, 8'(200 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) drive(1'b1, 8'(i + 17), 1'b1, 1'b0, 1'b0);
    check_eq("half_count", 32'(count), 8);
    repeat (10) drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // High-water mark: fill to 12, drain to 3, clear, then new peaks.
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check_eq("clr_empty", 32'(maxcount), 0);
    for (int i = 0; i < 12; i++) drive(1'b1, 8'(i + 40), 1'b0, 1'b0, 1'b0);
    check_eq("hwm_12", 32'(maxcount), 12);
    repeat (9) drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check_eq("hwm_cnt3", 32'(count), 3);
    check_eq("hwm_hold", 32'(maxcount), 12);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check_eq("hwm_clr", 32'(maxcount), 3);
    drive(1'b1, 8'h60, 1'b0, 1'b0, 1'b0);
    check_eq("hwm_4", 32'(maxcount), 4);
    drive(1'b1, 8'h61, 1'b0, 1'b0, 1'b0);
    check_eq("hwm_5", 32'(maxcount), 5);
    repeat (8) drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Reset mid-burst at count 9 with push and pop active.
    for (int i = 0; i < 9; i++) drive(1'b1, 8'(i + 80), 1'b0, 1'b0, 1'b0);
    check_eq("pre_rst_count", 32'(count), 9);
    drive(1'b1, 8'hEE, 1'b1, 1'b0, 1'b1);
    check_eq("mid_rst_count", 32'(count), 0);
    check_eq("mid_rst_tvalid", 32'(out_valid), 0);
    check_eq("mid_rst_tready", 32'(in_ready), 1);
    check_eq("mid_rst_max", 32'(maxcount), 0);
    for (int i = 0; i < 3; i++) drive(1'b1, 8'(i + 1), 1'b0, 1'b0, 1'b0);
    check_eq("post_rst_head", 32'(out_data), 1);
    repeat (4) drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check_eq("post_rst_empty", 32'(count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
